// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master issues start with operands; the slave reports busy/done with the result.
// WIDTH must match the subtractor instance it connects to.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin (mod 2^WIDTH), LSB first, one full-subtractor cell.
// Latency: done pulses WIDTH edges after the accepting edge; one result per WIDTH+1 cycles back-to-back.
// No backpressure: start is ignored while busy; result holds until the next accepted start.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic             borrow;
  logic             bout_q;
  logic [CW-1:0]    cnt;

  logic accept;
  logic x;
  logic y;
  logic d;
  logic borrow_next;

  // A new operation is taken only when not currently shifting bits.
  assign accept = bus.start && (state != RUN);

  // Single full-subtractor cell working on the current LSBs and stored borrow.
  assign x           = a_sr[0];
  assign y           = b_sr[0];
  assign d           = x ^ y ^ borrow;
  assign borrow_next = (~x & y) | (~(x ^ y) & borrow);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: RUN lasts exactly WIDTH bit-cycles, DONE lasts one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = DONE;
      DONE:    state_next = bus.start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load operands on accept, then shift one bit per cycle while running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      borrow  <= 1'b0;
      bout_q  <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      a_sr   <= bus.a;
      b_sr   <= bus.b;
      borrow <= bus.bin;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
      diff_sr <= {d, diff_sr[WIDTH-1:1]};
      borrow  <= borrow_next;
      cnt     <= cnt + 1'b1;
      // bout only changes when the final bit is produced, so it holds afterwards.
      if (cnt == LAST) bout_q <= borrow_next;
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.diff = diff_sr;
  assign bus.bout = bout_q;

endmodule
